seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
Sequential shift-and-add multiplier-accumulator that computes Producto = Multiplicando * Multiplicador + Sumando, one multiplier bit per clock. It is the inverse of the team's restoring divider. Feeding it Cociente, Divisor and Residuo reconstructs the original Dividendo, for checking or for recombination. It uses the same start/ready handshake and control-FSM + counter + datapath split as the divider.

Parameters:
DW, 8 (taken from the Global package), operand width in bits; Producto is 2*DW bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin operation; sampled only in IDLE
Multiplicando  input  DW  operand M, unsigned
Multiplicador  input  DW  operand Q, unsigned
Sumando  input  DW  addend (remainder term), unsigned, zero-extended
busy  output  1  high in RUN and DONE
ready  output  1  one-cycle pulse: Producto/ovf valid
Producto  output  2*DW  result, held until the next ready
ovf  output  1  Producto[2*DW-1:DW] != 0, updated together with Producto

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, busy=0, ready=0, Producto=0, ovf=0, internal acc/M/Q/count=0.
- rst high on any edge, including mid-RUN, aborts the operation. State returns to IDLE with reset values and no ready pulse.
- FSM states are IDLE, RUN and DONE.
- IDLE with start=1 at edge t0:
  - Load acc = {DW'0, Sumando}, Mreg = {DW'0, Multiplicando}, Qreg = Multiplicador, count = 0.
  - Go to RUN.
- IDLE with start=0: stay in IDLE; Producto/ovf hold.
- RUN, one step per edge:
  - If Qreg[0]=1, acc += Mreg (2*DW-bit add, cannot overflow 2*DW).
  - Then Mreg <<= 1, Qreg >>= 1, count++.
  - When count == DW-1 on that edge, the step is performed and the state goes to DONE.
  - RUN therefore occupies edges t1..tDW.
- DONE:
  - On the edge entering DONE, Producto <= final acc and ovf <= |final acc[2*DW-1:DW].
  - ready=1 for exactly the one cycle spent in DONE.
  - The next edge returns to IDLE unconditionally.
- Latency: ready is high in the cycle following edge tDW, i.e. DW cycles after the edge that sampled start.
- start while busy=1 is ignored, and operand changes during RUN are ignored (operands are registered at t0).
- start high in the DONE cycle is ignored. start held continuously produces back-to-back operations with one IDLE cycle between them.
- Boundary cases:
  - Multiplicador=0 gives Producto=Sumando.
  - All-ones operands give the maximum (2^DW-1)^2 + (2^DW-1) = 2^(2DW) - 2^DW, which fits in 2*DW bits; ovf=1.

Optional Feature:
MULT_EARLY_EXIT_EN
- Defined:
  - In RUN, if Qreg == 0 at an edge, no step is performed and the state goes directly to DONE.
  - Latency = min(msb_index(Multiplicador)+2, DW); Multiplicador=0 gives latency 1.
  - Results are identical to the undefined case.
- Undefined: fixed latency DW for every operand.

Decomposition:
- Global package:
  - existing DW;
  - localparam CNT_W = $clog2(DW);
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_e;
  - typedef logic [2*DW-1:0] prod_t.
- One sub-module, mult_datapath:
  - contains acc/Mreg/Qreg, the conditional adder and the shifters;
  - inputs: load, step, capture;
  - outputs: Producto, ovf, q_zero.
- FSM and count stay in seq_multiplier. The existing Counter may be reused with a DW-1 terminal.

Test Plan (DW=8):
1. Reset: rst=1 for 2 cycles with start=1 -> busy=0, ready=0, Producto=0, ovf=0; no operation starts.
2. Multiplicando=7, Multiplicador=13, Sumando=4, start pulse -> ready exactly 8 cycles after the start edge, for 1 cycle; Producto=95, ovf=0; Producto still 95 afterwards.
3. Multiplicando=255, Multiplicador=255, Sumando=255 -> Producto=0xFF00 (65280), ovf=1. Divider round-trip: 200/7 gives Cociente=28, Residuo=4, fed as 28*7+4 -> Producto=200.
4. Start operands 3,5,0; during RUN raise start again with operands 9,9,9 -> single ready pulse, Producto=15; second request ignored; a new start after ready gives 90.
5. Start 100*100+1, then rst=1 on the 4th RUN edge -> next cycle IDLE, Producto=0, no ready pulse. Restart 2*3+1 -> 7.
6. Multiplicador=0, Sumando=9: with MULT_EARLY_EXIT_EN, ready 1 cycle after start, Producto=9; without, 8 cycles. Multiplicador=1, Multiplicando=6 with the macro -> latency 2, Producto=6.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared types and widths for the shift-and-add multiplier-accumulator.
// DW sets the operand width; Producto is 2*DW bits wide.
package seq_multiplier_pkg;

    localparam int DW    = 8;
    localparam int CNT_W = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_e;

    typedef logic [2*DW-1:0] prod_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/ready operand and result bundle of the multiplier-accumulator.
// master drives the operation request; slave is the multiplier.
interface seq_multiplier_if;
    import seq_multiplier_pkg::*;

    logic          start;
    logic [DW-1:0] Multiplicando;
    logic [DW-1:0] Multiplicador;
    logic [DW-1:0] Sumando;
    logic          busy;
    logic          ready;
    prod_t         Producto;
    logic          ovf;

    modport master (
        output start, Multiplicando, Multiplicador, Sumando,
        input  busy, ready, Producto, ovf
    );

    modport slave (
        input  start, Multiplicando, Multiplicador, Sumando,
        output busy, ready, Producto, ovf
    );

endinterface

// File: rtl/seq_multiplier_datapath.sv
// Accumulator, shifted multiplicand and multiplier registers with the
// conditional adder; captures the final accumulator into Producto/ovf.
module mult_datapath
    import seq_multiplier_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          step_i,
    input  logic          capture_i,
    input  logic [DW-1:0] mcand_i,
    input  logic [DW-1:0] mplier_i,
    input  logic [DW-1:0] addend_i,
    output prod_t         prod_o,
    output logic          ovf_o,
    output logic          q_zero_o
);

    prod_t         acc_q, acc_d;
    prod_t         m_q, m_d;
    logic [DW-1:0] q_q, q_d;
    prod_t         prod_q, prod_d;
    logic          ovf_q, ovf_d;
    prod_t         acc_step;
    prod_t         acc_fin;

    // Sum of a DW-bit addend and DW-bit x DW-bit product fits in 2*DW bits.
    assign acc_step = q_q[0] ? acc_q + m_q : acc_q;
    assign acc_fin  = step_i ? acc_step : acc_q;

    always_comb begin
        acc_d  = acc_q;
        m_d    = m_q;
        q_d    = q_q;
        prod_d = prod_q;
        ovf_d  = ovf_q;
        if (load_i) begin
            acc_d = {{DW{1'b0}}, addend_i};
            m_d   = {{DW{1'b0}}, mcand_i};
            q_d   = mplier_i;
        end else if (step_i) begin
            acc_d = acc_step;
            m_d   = m_q << 1;
            q_d   = q_q >> 1;
        end
        if (capture_i) begin
            prod_d = acc_fin;
            ovf_d  = |acc_fin[2*DW-1:DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            m_q    <= '0;
            q_q    <= '0;
            prod_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            m_q    <= m_d;
            q_q    <= q_d;
            prod_q <= prod_d;
            ovf_q  <= ovf_d;
        end
    end

    assign prod_o   = prod_q;
    assign ovf_o    = ovf_q;
    assign q_zero_o = (q_q == '0);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential multiply-accumulate: Producto = M * Q + Sumando, one bit/clock.
// Define MULT_EARLY_EXIT_EN to finish as soon as the multiplier runs out of ones.
module seq_multiplier
    import seq_multiplier_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    seq_multiplier_if.slave    bus
);

    mult_state_e      state_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             ready_q;
    logic             q_zero;
    logic             early;
    logic             last;
    logic             load;
    logic             step;
    logic             capture;

`ifdef MULT_EARLY_EXIT_EN
    assign early = q_zero;
`else
    logic unused_q_zero;
    assign unused_q_zero = q_zero;
    assign early = 1'b0;
`endif

    assign last    = (count_q == CNT_W'(DW - 1));
    assign load    = (state_q == IDLE) && bus.start;
    assign step    = (state_q == RUN) && !early;
    assign capture = (state_q == RUN) && (early || last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (step) count_q <= count_q + CNT_W'(1);
                    if (capture) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    mult_datapath u_dp (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .step_i    (step),
        .capture_i (capture),
        .mcand_i   (bus.Multiplicando),
        .mplier_i  (bus.Multiplicador),
        .addend_i  (bus.Sumando),
        .prod_o    (bus.Producto),
        .ovf_o     (bus.ovf),
        .q_zero_o  (q_zero)
    );

    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, hand-written
// corner sequences and random operands against an arithmetic model.
module tb_seq_multiplier;
    import seq_multiplier_pkg::*;

    typedef struct packed {
        logic [DW-1:0]   m;
        logic [DW-1:0]   q;
        logic [DW-1:0]   s;
        logic [2*DW-1:0] p;
        logic            o;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    seq_multiplier_if bus ();

    seq_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int exp_lat(input logic [DW-1:0] q);
`ifdef MULT_EARLY_EXIT_EN
        int msb = -1;
        for (int i = 0; i < DW; i++) if (q[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + 2 < DW) ? msb + 2 : DW;
`else
        return DW;
`endif
    endfunction

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_op(input logic [DW-1:0] m, input logic [DW-1:0] q,
                          input logic [DW-1:0] s, input string nm);
        int unsigned ep;
        int          cyc;
        logic        got;
        ep = int'(m) * int'(q) + int'(s);
        bus.Multiplicando = m;
        bus.Multiplicador = q;
        bus.Sumando       = s;
        bus.start         = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.ready) got = 1'b1;
        end
        chk({nm, " ready"}, 32'(got), 32'd1);
        chk({nm, " latency"}, 32'(cyc), 32'(exp_lat(q)));
        chk({nm, " Producto"}, 32'(bus.Producto), ep);
        chk({nm, " ovf"}, 32'(bus.ovf), 32'((ep >> DW) != 0));
        chk({nm, " busy in done"}, 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        chk({nm, " ready drop"}, 32'(bus.ready), 32'd0);
        chk({nm, " busy drop"}, 32'(bus.busy), 32'd0);
        chk({nm, " held"}, 32'(bus.Producto), ep);
    endtask

    vec_t vecs [6];
    int   pulses;
    int   cq, rr;

    initial begin
        bus.start         = 1'b1;
        bus.Multiplicando = 8'd5;
        bus.Multiplicador = 8'd5;
        bus.Sumando       = 8'd5;

        vecs[0] = '{m: 8'd7,   q: 8'd13,  s: 8'd4,   p: 16'd95,    o: 1'b0};
        vecs[1] = '{m: 8'd255, q: 8'd255, s: 8'd255, p: 16'hFF00,  o: 1'b1};
        vecs[2] = '{m: 8'd1,   q: 8'd0,   s: 8'd9,   p: 16'd9,     o: 1'b0};
        vecs[3] = '{m: 8'd6,   q: 8'd1,   s: 8'd0,   p: 16'd6,     o: 1'b0};
        vecs[4] = '{m: 8'd16,  q: 8'd16,  s: 8'd0,   p: 16'd256,   o: 1'b1};
        vecs[5] = '{m: 8'd0,   q: 8'd200, s: 8'd77,  p: 16'd77,    o: 1'b0};

        // Reset held with start asserted: nothing may begin.
        @(posedge clk); @(posedge clk); #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst ready", 32'(bus.ready), 32'd0);
        chk("rst Producto", 32'(bus.Producto), 32'd0);
        chk("rst ovf", 32'(bus.ovf), 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst idle", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].m, vecs[i].q, vecs[i].s, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d table p", i), 32'(bus.Producto),
                32'(vecs[i].p));
            chk($sformatf("vec%0d table ovf", i), 32'(bus.ovf),
                32'(vecs[i].o));
        end

        // Divider round-trip: 200 / 7 recombined.
        cq = 200 / 7;
        rr = 200 % 7;
        run_op(8'(cq), 8'd7, 8'(rr), "roundtrip");
        chk("roundtrip value", 32'(bus.Producto), 32'd200);

        // Second start during RUN is ignored.
        bus.Multiplicando = 8'd3;
        bus.Multiplicador = 8'd5;
        bus.Sumando       = 8'd0;
        bus.start         = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.Multiplicando = 8'd9;
        bus.Multiplicador = 8'd9;
        bus.Sumando       = 8'd9;
        bus.start         = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12 && pulses == 0; c++) begin
            @(posedge clk); #1;
            if (bus.ready) begin
                pulses++;
                bus.start = 1'b0;
                chk("ignore Producto", 32'(bus.Producto), 32'd15);
            end
        end
        bus.start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.ready) pulses++;
        end
        chk("ignore pulses", 32'(pulses), 32'd1);
        chk("ignore idle", 32'(bus.busy), 32'd0);
        run_op(8'd9, 8'd9, 8'd9, "after ignore");

        // Reset on the 4th RUN edge aborts without a ready pulse.
        bus.Multiplicando = 8'd100;
        bus.Multiplicador = 8'd100;
        bus.Sumando       = 8'd1;
        bus.start         = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort Producto", 32'(bus.Producto), 32'd0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.ready || bus.busy) pulses++;
        end
        chk("abort quiet", 32'(pulses), 32'd0);
        run_op(8'd2, 8'd3, 8'd1, "restart");

        // Random operands against m*q+s.
        for (int n = 0; n < 24; n++) begin
            logic [DW-1:0] rq;
            rq = 8'($urandom_range(0, 255) >> $urandom_range(0, 8));
            run_op(8'($urandom_range(0, 255)), rq,
                   8'($urandom_range(0, 255)), $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
